// File: rtl/ipg_pkg.sv
// Shared constants for the IPG receive path: block types, position nibbles,
// message classes and error codes.
package ipg_pkg;

  typedef logic [1:0] msg_cls_t;
  typedef logic [1:0] err_code_t;

  // Full block-type bytes, one FIRST / MIDDLE / LAST triple per class
  localparam logic [7:0] BT_READ_FIRST  = 8'h2a;
  localparam logic [7:0] BT_READ        = 8'h1a;
  localparam logic [7:0] BT_READ_LAST   = 8'h0a;
  localparam logic [7:0] BT_WRITE_FIRST = 8'h2b;
  localparam logic [7:0] BT_WRITE       = 8'h1b;
  localparam logic [7:0] BT_WRITE_LAST  = 8'h0b;
  localparam logic [7:0] BT_RRESP_FIRST = 8'h2c;
  localparam logic [7:0] BT_RRESP       = 8'h1c;
  localparam logic [7:0] BT_RRESP_LAST  = 8'h0c;
  localparam logic [7:0] BT_CTRL        = 8'h1e;

  // Position nibble, taken from block type bits [7:4]
  localparam logic [3:0] POS_FIRST = 4'h2;
  localparam logic [3:0] POS_MID   = 4'h1;
  localparam logic [3:0] POS_LAST  = 4'h0;

  localparam msg_cls_t CLS_RREQ  = 2'd0;
  localparam msg_cls_t CLS_WREQ  = 2'd1;
  localparam msg_cls_t CLS_RRESP = 2'd2;

  localparam err_code_t ERR_NONE   = 2'd0;
  localparam err_code_t ERR_ORPHAN = 2'd1;
  localparam err_code_t ERR_ABORT  = 2'd2;
  localparam err_code_t ERR_BUSY   = 2'd3;

  // Class of a block from its strobes; only meaningful when exactly one is set
  function automatic msg_cls_t cls_of_flags(input logic rreq, input logic wreq);
    if (rreq)      return CLS_RREQ;
    else if (wreq) return CLS_WREQ;
    else           return CLS_RRESP;
  endfunction

endpackage

// File: rtl/ipg_msg_outreg.sv
// Single-entry valid/ready holding register for assembled messages.
// A load that arrives while a message is held and not being taken is
// refused and flagged as busy; the held message is left untouched.
module ipg_msg_outreg
  import ipg_pkg::*;
#(
  parameter int DW = 224
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  msg_cls_t      load_type,
  input  logic [3:0]    load_blocks,
  input  logic [DW-1:0] load_data,
  input  logic          msg_ready,
  output logic          msg_valid,
  output msg_cls_t      msg_type,
  output logic [3:0]    msg_blocks,
  output logic [DW-1:0] msg_data,
  output logic          busy
);

  logic          valid_reg;
  msg_cls_t      type_reg;
  logic [3:0]    blocks_reg;
  logic [DW-1:0] data_reg;

  assign busy       = load_valid && valid_reg && !msg_ready;
  assign msg_valid  = valid_reg;
  assign msg_type   = type_reg;
  assign msg_blocks = blocks_reg;
  assign msg_data   = data_reg;

  // Load when empty or draining this cycle; otherwise clear on transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      type_reg   <= '0;
      blocks_reg <= '0;
      data_reg   <= '0;
    end else if (load_valid && (!valid_reg || msg_ready)) begin
      valid_reg  <= 1'b1;
      type_reg   <= load_type;
      blocks_reg <= load_blocks;
      data_reg   <= load_data;
    end else if (valid_reg && msg_ready) begin
      valid_reg  <= 1'b0;
    end
  end

endmodule

// File: rtl/ipg_rx_reassembler.sv
// Reassembles FIRST / MIDDLE / LAST IPG control blocks into messages and
// hands them to a single-entry output register. The line cannot stall, so
// malformed sequences and refused deliveries drop whole messages and count.
module ipg_rx_reassembler
  import ipg_pkg::*;
#(
  parameter int MAX_BLOCKS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             rx_ipg_data,
  input  logic                    rreq_valid,
  input  logic                    wreq_valid,
  input  logic                    rresp_valid,
  output logic                    msg_valid,
  input  logic                    msg_ready,
  output logic [1:0]              msg_type,
  output logic [3:0]              msg_blocks,
  output logic [56*MAX_BLOCKS-1:0] msg_data,
  output logic                    err_valid,
  output logic [1:0]              err_code,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int DW = 56 * MAX_BLOCKS;
  localparam logic [3:0] LAST_MID_IDX = 4'(MAX_BLOCKS - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ASSEMBLE = 2'd1;
  localparam logic [1:0] ST_DISCARD  = 2'd2;

  // Input decode: a block counts only when exactly one strobe is high
  logic [2:0]  flags;
  logic        one_hot;
  msg_cls_t    in_cls;
  logic [3:0]  pos;
  logic [55:0] payload;
  logic        is_first, is_mid, is_last;
  logic        unused_type_low;

  assign flags    = {rresp_valid, wreq_valid, rreq_valid};
  assign one_hot  = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  assign in_cls   = cls_of_flags(rreq_valid, wreq_valid);
  assign pos      = rx_ipg_data[7:4];
  assign payload  = rx_ipg_data[63:8];
  assign is_first = one_hot && (pos == POS_FIRST);
  assign is_mid   = one_hot && (pos == POS_MID);
  assign is_last  = one_hot && (pos == POS_LAST);
  // The low type nibble repeats the class already given by the strobes
  assign unused_type_low = ^rx_ipg_data[3:0];

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  msg_cls_t    cls_reg, cls_next;
  logic [55:0] blk_reg [MAX_BLOCKS];

  logic        wr_en;
  logic [3:0]  wr_idx;
  logic        deliver;
  logic [3:0]  deliver_base;
  logic [3:0]  deliver_blocks;
  logic [DW-1:0] deliver_data;
  logic        restart;
  logic        abort, orphan, busy;

  // Next-state logic; an aborted message falls through to IDLE handling
  // of the same block so no input cycle is lost
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cls_next       = cls_reg;
    wr_en          = 1'b0;
    wr_idx         = '0;
    deliver        = 1'b0;
    deliver_base   = '0;
    deliver_blocks = '0;
    restart        = 1'b0;
    abort          = 1'b0;
    orphan         = 1'b0;
    case (state_reg)
      ST_ASSEMBLE: begin
        if (is_first || ((is_mid || is_last) && (in_cls != cls_reg))) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
          restart    = 1'b1;
        end else if (is_mid) begin
          if (cnt_reg < LAST_MID_IDX) begin
            wr_en    = 1'b1;
            wr_idx   = cnt_reg;
            cnt_next = cnt_reg + 4'd1;
          end else begin
            abort      = 1'b1;
            state_next = ST_DISCARD;
          end
        end else if (is_last) begin
          deliver        = 1'b1;
          deliver_base   = cnt_reg;
          deliver_blocks = cnt_reg + 4'd1;
          state_next     = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (is_last)       state_next = ST_IDLE;
        else if (is_first) restart    = 1'b1;
      end
      default: restart = 1'b1;
    endcase

    if (restart) begin
      if (is_first) begin
        wr_en      = 1'b1;
        wr_idx     = '0;
        cnt_next   = 4'd1;
        cls_next   = in_cls;
        state_next = ST_ASSEMBLE;
      end else if (is_last) begin
        deliver        = 1'b1;
        deliver_base   = '0;
        deliver_blocks = 4'd1;
        state_next     = ST_IDLE;
      end else if (is_mid) begin
        orphan     = 1'b1;
        state_next = ST_IDLE;
      end
    end
  end

  // FSM, count and class registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      cls_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cls_reg   <= cls_next;
    end
  end

  // Assembly buffer plus delivery image: stored blocks below the base,
  // the incoming LAST payload at the base, zeros above
  for (genvar gi = 0; gi < MAX_BLOCKS; gi++) begin : g_blk
    // Per-slot buffer write
    always_ff @(posedge clk) begin
      if (rst)                               blk_reg[gi] <= '0;
      else if (wr_en && (wr_idx == 4'(gi)))  blk_reg[gi] <= payload;
    end
    assign deliver_data[56*gi +: 56] = (4'(gi) < deliver_base)  ? blk_reg[gi] :
                                       (4'(gi) == deliver_base) ? payload     : 56'd0;
  end

  ipg_msg_outreg #(.DW(DW)) u_outreg (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (deliver),
    .load_type   (in_cls),
    .load_blocks (deliver_blocks),
    .load_data   (deliver_data),
    .msg_ready   (msg_ready),
    .msg_valid   (msg_valid),
    .msg_type    (msg_type),
    .msg_blocks  (msg_blocks),
    .msg_data    (msg_data),
    .busy        (busy)
  );

  // Error pulse and saturating drop counter. An abort can coincide with an
  // orphan or busy drop from the same block; each drop counts, and the
  // abort code is the one reported.
  logic [1:0]       drop_inc;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_reg;
  logic             err_valid_reg;
  err_code_t        err_code_reg;

  assign drop_inc = {1'b0, abort} + {1'b0, orphan} + {1'b0, busy};
  assign drop_sum = {1'b0, drop_reg} + (CNT_W+1)'(drop_inc);

  // Register error reporting and drop count
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
      drop_reg      <= '0;
    end else begin
      err_valid_reg <= abort || orphan || busy;
      err_code_reg  <= abort  ? ERR_ABORT  :
                       orphan ? ERR_ORPHAN :
                       busy   ? ERR_BUSY   : ERR_NONE;
      drop_reg      <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

  assign err_valid  = err_valid_reg;
  assign err_code   = err_code_reg;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_ipg_rx_reassembler.sv
// Randomized self-checking bench for ipg_rx_reassembler against a
// message-level reference model built from queues of payloads.
module tb_ipg_rx_reassembler;

  localparam int MAXB  = 4;
  localparam int CNT_W = 16;
  localparam int DW    = 56 * MAXB;

  localparam logic [2:0] F_NONE  = 3'b000;
  localparam logic [2:0] F_RREQ  = 3'b001;
  localparam logic [2:0] F_WREQ  = 3'b010;
  localparam logic [2:0] F_RRESP = 3'b100;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      rx_ipg_data;
  logic             rreq_valid, wreq_valid, rresp_valid;
  logic             msg_valid, msg_ready;
  logic [1:0]       msg_type;
  logic [3:0]       msg_blocks;
  logic [DW-1:0]    msg_data;
  logic             err_valid;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] drop_count;

  ipg_rx_reassembler #(.MAX_BLOCKS(MAXB), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_ipg_data (rx_ipg_data),
    .rreq_valid  (rreq_valid),
    .wreq_valid  (wreq_valid),
    .rresp_valid (rresp_valid),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_type    (msg_type),
    .msg_blocks  (msg_blocks),
    .msg_data    (msg_data),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [447:0] got, input logic [447:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: partial message as a payload queue
  bit               in_msg, discarding;
  bit [1:0]         part_cls;
  logic [55:0]      part[$];
  bit               exp_valid, exp_err_valid;
  bit [1:0]         exp_type, exp_err_code;
  bit [3:0]         exp_blocks;
  bit [DW-1:0]      exp_data;
  bit [CNT_W-1:0]   exp_drop;

  task automatic model_reset();
    in_msg = 0; discarding = 0; part_cls = 0; part.delete();
    exp_valid = 0; exp_type = 0; exp_blocks = 0; exp_data = '0;
    exp_err_valid = 0; exp_err_code = 0; exp_drop = 0;
  endtask

  task automatic model_step(input logic [63:0] d, input logic [2:0] fl, input logic rdy);
    bit abort = 0, orphan = 0, busy = 0, fresh = 0, deliver = 0, held;
    logic [55:0] dq[$];
    bit [1:0] cls;
    logic [3:0] pos;
    logic [55:0] pl;
    int ndrop;
    pos = d[7:4];
    pl  = d[63:8];
    cls = fl[0] ? 2'd0 : fl[1] ? 2'd1 : 2'd2;
    if ($countones(fl) == 1 && pos <= 4'h2) begin
      if (in_msg) begin
        if (pos == 4'h2 || cls != part_cls) begin
          abort = 1; in_msg = 0; fresh = 1;
        end else if (pos == 4'h1) begin
          if (part.size() == MAXB - 1) begin
            abort = 1; in_msg = 0; discarding = 1;
          end else part.push_back(pl);
        end else begin
          part.push_back(pl); dq = part; deliver = 1; in_msg = 0;
        end
      end else if (discarding) begin
        if (pos == 4'h0) discarding = 0;
        else if (pos == 4'h2) fresh = 1;
      end else fresh = 1;
      if (fresh) begin
        discarding = 0;
        if (pos == 4'h2) begin
          part.delete(); part.push_back(pl); part_cls = cls; in_msg = 1;
        end else if (pos == 4'h0) begin
          dq.delete(); dq.push_back(pl); deliver = 1;
        end else orphan = 1;
      end
    end
    held = exp_valid && !rdy;
    if (exp_valid && rdy) exp_valid = 0;
    if (deliver) begin
      if (held) busy = 1;
      else begin
        exp_valid = 1; exp_type = cls; exp_blocks = 4'(dq.size()); exp_data = '0;
        foreach (dq[i]) exp_data[56*i +: 56] = dq[i];
      end
    end
    ndrop = int'(abort) + int'(orphan) + int'(busy);
    repeat (ndrop) if (exp_drop != '1) exp_drop++;
    exp_err_valid = abort | orphan | busy;
    exp_err_code  = abort ? 2'd2 : orphan ? 2'd1 : busy ? 2'd3 : 2'd0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 448'(msg_valid), 448'(exp_valid));
    if (exp_valid) begin
      check({tag, ".type"},   448'(msg_type),   448'(exp_type));
      check({tag, ".blocks"}, 448'(msg_blocks), 448'(exp_blocks));
      check({tag, ".data"},   448'(msg_data),   448'(exp_data));
    end
    check({tag, ".err_valid"}, 448'(err_valid),  448'(exp_err_valid));
    check({tag, ".err_code"},  448'(err_code),   448'(exp_err_code));
    check({tag, ".drops"},     448'(drop_count), 448'(exp_drop));
  endtask

  // One input cycle: drive, advance the model, sample #1 after the edge
  task automatic cycle(input logic [63:0] d, input logic [2:0] fl, input logic rdy, input string tag);
    rx_ipg_data = d;
    {rresp_valid, wreq_valid, rreq_valid} = fl;
    msg_ready = rdy;
    if (rst) model_reset();
    else     model_step(d, fl, rdy);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  function automatic logic [63:0] mk(input logic [7:0] t, input logic [55:0] p);
    return {p, t};
  endfunction

  localparam logic [55:0] PA = 56'haaaa_0000_0000_01;
  localparam logic [55:0] PB = 56'hbbbb_0000_0000_02;
  localparam logic [55:0] PC = 56'hcccc_0000_0000_03;

  logic [DW-1:0] held_data;
  logic [2:0]    last_fl;

  initial begin
    rst = 1'b1; rx_ipg_data = '0; msg_ready = 1'b0;
    {rresp_valid, wreq_valid, rreq_valid} = F_NONE;
    model_reset();
    cycle(64'd0, F_NONE, 1'b0, "reset");
    check("reset.data", 448'(msg_data), 448'd0);
    rst = 1'b0;

    // Three-block read request
    cycle(mk(8'h2a, PA), F_RREQ, 1'b1, "t1.first");
    cycle(mk(8'h1a, PB), F_RREQ, 1'b1, "t1.mid");
    cycle(mk(8'h0a, PC), F_RREQ, 1'b1, "t1.last");
    check("t1.abc", 448'(msg_data), 448'({56'd0, PC, PB, PA}));
    check("t1.nblk", 448'(msg_blocks), 448'd3);
    cycle(64'd0, F_NONE, 1'b1, "t1.drain");

    // Single-block write request
    cycle(mk(8'h0c, 56'h11223344556677), F_WREQ, 1'b1, "t2.single");
    check("t2.type", 448'(msg_type), 448'd1);
    check("t2.data", 448'(msg_data), 448'(56'h11223344556677));
    cycle(64'd0, F_NONE, 1'b1, "t2.drain");

    // Orphan middle
    cycle(mk(8'h1b, PA), F_RRESP, 1'b1, "t3.orphan");
    check("t3.code", 448'(err_code), 448'd1);

    // Too many blocks, then a lone LAST (ends discard), then a lone LAST delivers
    cycle(mk(8'h2a, PA), F_RREQ, 1'b1, "t4.first");
    for (int i = 0; i < 3; i++) cycle(mk(8'h1a, PB + 56'(i)), F_RREQ, 1'b1, "t4.mid");
    cycle(mk(8'h0a, PC), F_RREQ, 1'b1, "t4.last");
    cycle(mk(8'h0a, PC), F_RREQ, 1'b1, "t4.single");
    cycle(64'd0, F_NONE, 1'b1, "t4.drain");

    // Output busy drop while message 1 is held
    cycle(mk(8'h0a, PA), F_RREQ, 1'b0, "t5.msg1");
    held_data = msg_data;
    cycle(mk(8'h2b, PB), F_WREQ, 1'b0, "t5.first");
    cycle(mk(8'h0b, PC), F_WREQ, 1'b0, "t5.last");
    cycle(64'd0, F_NONE, 1'b0, "t5.hold");
    check("t5.code", 448'(err_code), 448'd0);
    check("t5.held", 448'(msg_data), 448'(held_data));
    cycle(64'd0, F_NONE, 1'b1, "t5.xfer");
    cycle(64'd0, F_NONE, 1'b1, "t5.empty");

    // Class change aborts; new FIRST restarts
    cycle(mk(8'h2a, PA), F_RREQ, 1'b1, "t6.rfirst");
    cycle(mk(8'h2b, PB), F_WREQ, 1'b1, "t6.wfirst");
    check("t6.code", 448'(err_code), 448'd2);
    cycle(mk(8'h0b, PC), F_WREQ, 1'b1, "t6.wlast");
    check("t6.nblk", 448'(msg_blocks), 448'd2);

    // Reset in the middle of a message
    cycle(mk(8'h2c, PA), F_RRESP, 1'b0, "t7.first");
    rst = 1'b1;
    cycle(mk(8'h1c, PB), F_RRESP, 1'b0, "t7.rst");
    check("t7.data", 448'(msg_data), 448'd0);
    rst = 1'b0;

    // Randomized traffic
    last_fl = F_RREQ;
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [2:0] fl;
      logic [3:0] p;
      logic [7:0] t;
      r = int'($urandom_range(0, 99));
      if (r < 8)       fl = F_NONE;
      else if (r < 12) fl = 3'b011 + 3'($urandom_range(0, 3) == 0 ? 4 : $urandom_range(0, 2) * 2);
      else if ($urandom_range(0, 9) < 8) fl = last_fl;
      else begin
        case ($urandom_range(0, 2))
          0:       fl = F_RREQ;
          1:       fl = F_WREQ;
          default: fl = F_RRESP;
        endcase
      end
      if ($countones(fl) == 1) last_fl = fl;
      r = int'($urandom_range(0, 99));
      p = (r < 25) ? 4'h2 : (r < 65) ? 4'h1 : (r < 95) ? 4'h0 : 4'(3 + $urandom_range(0, 12));
      t = {p, fl[0] ? 4'ha : fl[1] ? 4'hb : 4'hc};
      rst = ($urandom_range(0, 299) == 0);
      cycle(mk(t, {$urandom, $urandom} & 56'hff_ffff_ffff_ffff), fl,
            ($urandom_range(0, 3) != 0), "rand");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipg_rx_reassembler.md
Name: ipg_rx_reassembler

Overview:
- Sits directly downstream of the IPG receive decoder.
- Consumes one decoded 64-bit IPG control block per cycle. Each block arrives as rx_ipg_data plus exactly one of rreq_valid, wreq_valid or rresp_valid.
- Reassembles FIRST / MIDDLE / LAST block sequences into one message of up to MAX_BLOCKS x 56 payload bits. Presents each message on a valid/ready output to the read/write request logic.
- The line cannot be back-pressured, so protocol errors and output-busy conditions drop whole messages and are counted.

Parameters:
- MAX_BLOCKS, 4, maximum 56-bit blocks per message (2..8).
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- rx_ipg_data  in  64  decoded block: [7:0] block type, [63:8] payload.
- rreq_valid  in  1  block belongs to a read-request message.
- wreq_valid  in  1  block belongs to a write-request message.
- rresp_valid  in  1  block belongs to a read-response message.
- msg_valid  out  1  assembled message available.
- msg_ready  in  1  consumer accepts the message.
- msg_type  out  2  message class: 0 = rreq, 1 = wreq, 2 = rresp.
- msg_blocks  out  4  number of blocks in the message (1..MAX_BLOCKS).
- msg_data  out  56*MAX_BLOCKS  payload; block i at [56*i+55:56*i]; unused blocks are zero.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  1 = orphan, 2 = overflow/abort, 3 = output busy.
- drop_count  out  CNT_W  saturating count of dropped messages.

Behaviour:
- Input strobe: exactly one valid flag high. Two or more flags high in a cycle is treated as no input.
- Block position comes from rx_ipg_data[7:4]:
  - 4'h2 = FIRST (types 0x2a / 0x2b / 0x2c).
  - 4'h1 = MIDDLE (0x1a / 0x1b / 0x1c).
  - 4'h0 = LAST (0x0a / 0x0b / 0x0c).
  - Any other value: block ignored.
- Reset values: all state cleared, FSM in IDLE, and every output is 0 (msg_valid, msg_type, msg_blocks, msg_data, err_valid, err_code, drop_count).
- FSM states: IDLE, ASSEMBLE, DISCARD. The assembly buffer, block count (cnt) and class (cls) are registers.
- IDLE:
  - FIRST: store the payload at block 0, cnt = 1, cls = class, go to ASSEMBLE.
  - LAST: single-block message; deliver with cnt = 1.
  - MIDDLE: err code 1, drop++, stay in IDLE.
- ASSEMBLE:
  - MIDDLE of the same class with cnt < MAX_BLOCKS-1: append at block cnt, cnt++.
  - MIDDLE of the same class with cnt = MAX_BLOCKS-1: err code 2, drop++, go to DISCARD.
  - LAST of the same class with cnt < MAX_BLOCKS: append the block, deliver with cnt+1.
  - FIRST (any class), or any block of a different class: err code 2, drop++, abandon the partial message. The new block is then processed exactly as in IDLE in the same cycle.
- DISCARD:
  - Ignore MIDDLE blocks.
  - LAST: return to IDLE with no further error and no count.
  - FIRST: restart exactly as in IDLE.
- Delivery:
  - msg_valid rises on the cycle after the LAST block is sampled.
  - The buffer is copied into the output register and unused upper blocks are zeroed.
  - The FSM returns to IDLE in the same cycle.
- Output handshake:
  - msg_data, msg_type and msg_blocks stay stable while msg_valid && !msg_ready.
  - Transfer occurs when msg_valid && msg_ready. msg_valid then clears unless a new delivery lands in that same cycle; in that case the new message is loaded and msg_valid stays 1 (back-to-back).
- Output busy: a delivery while msg_valid && !msg_ready drops the new message with err code 3, drop++. The held message is untouched.
- drop_count saturates at all-ones and never wraps.
- err_valid is a registered one-cycle pulse.
- Reset asserted mid-message discards partial and held messages without error.
- Throughput: one input block per cycle with no bubbles. A LAST followed immediately by a FIRST is accepted.

Decomposition:
- Shared package ipg_pkg holds:
  - Block-type constants (READ / WRITE / RRESP with their FIRST / LAST variants, CTRL 0x1e).
  - Position nibble constants POS_FIRST / POS_MID / POS_LAST.
  - Message-class encodings and err_code encodings.
- One natural sub-module: ipg_msg_outreg, the single-entry valid/ready holding register with busy-drop detect.

Test Plan:
- rreq 0x2a payload A, 0x1a payload B, 0x0a payload C on consecutive cycles, msg_ready=1 -> one cycle later: msg_valid=1, msg_type=0, msg_blocks=3, msg_data[167:0]={C,B,A}, upper 56 bits zero.
- Single wreq 0x0c with payload 56'h11223344556677 -> msg_type=1, msg_blocks=1, msg_data[55:0]=56'h11223344556677.
- rresp 0x1b while IDLE -> err_valid pulse with err_code=1, drop_count=1, no msg_valid.
- MAX_BLOCKS=4: FIRST + 3 MIDDLE + LAST -> err_code=2 on the 4th block, drop_count=1, no message. A following 0x0a alone delivers normally.
- Hold msg_ready=0 after message 1, then complete message 2 -> err_code=3, message 1 data unchanged. Raising msg_ready then gives exactly one transfer.
- rreq FIRST, then wreq FIRST, then wreq LAST -> err_code=2 once; delivered msg_type=1, msg_blocks=2. Assert rst mid-message -> all outputs 0 next cycle.
